// File: rtl/kes_mem_pkg.sv
// Shared constants and types for the KES memory arbiter.
package kes_mem_pkg;

  // Default SRAM256x32 geometry.
  localparam int KES_AW = 8;
  localparam int KES_DW = 32;

  // Requester indices: CPU fetch/operand/store path and loader/debug port.
  localparam int REQ_CPU    = 0;
  localparam int REQ_LOADER = 1;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/kes_rr_arb2.sv
// Two-way winner select: a lone request always wins; on a tie, either
// requester 0 wins (fixed priority) or the one that did not win last time.
module kes_rr_arb2
  import kes_mem_pkg::*;
#(
  parameter int FIXED_PRI = 0
)(
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic [1:0] gnt,
  output logic       winner
);

  // Combinational one-hot grant plus the index of the winner.
  always_comb begin
    gnt    = 2'b00;
    winner = 1'b0;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        winner = 1'(REQ_CPU);
      end
      2'b10: begin
        gnt    = 2'b10;
        winner = 1'(REQ_LOADER);
      end
      2'b11: begin
        if ((FIXED_PRI != 0) || (last_winner == 1'(REQ_LOADER))) begin
          gnt    = 2'b01;
          winner = 1'(REQ_CPU);
        end else begin
          gnt    = 2'b10;
          winner = 1'(REQ_LOADER);
        end
      end
      default: begin
        gnt    = 2'b00;
        winner = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/kes_mem_arbiter.sv
// Arbitrates the single SRAM start/write/done port between the KES CPU
// (requester 0) and the loader/debug port (requester 1).
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and keeps
// req high until ackN. ackN is a one-cycle pulse, and errN pulses with it
// when the SRAM never answered. The granted requester's fields are captured
// at grant, so changing them (or dropping req) afterwards has no effect on
// the transaction in flight. Towards the SRAM, mem_start stays high until
// mem_done is seen (or the timeout hits); a new start is only issued once
// mem_done has been observed low again.
module kes_mem_arbiter
  import kes_mem_pkg::*;
#(
  parameter int AW        = KES_AW,
  parameter int DW        = KES_DW,
  parameter int TIMEOUT   = 64,
  parameter int FIXED_PRI = 0
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_start,
  input  logic          mem_done,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant,
  output logic          busy,
  output logic [1:0]    fsm_state
);

  // Last ISSUE count value before the transaction is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       last_winner;
  logic [1:0] req_vec;
  logic [1:0] arb_gnt;
  logic       arb_winner;

  assign req_vec[REQ_CPU]    = req0;
  assign req_vec[REQ_LOADER] = req1;

  // Current state is visible for debug and checkers.
  assign fsm_state = state;

  kes_rr_arb2 #(
    .FIXED_PRI (FIXED_PRI)
  ) u_arb (
    .req         (req_vec),
    .last_winner (last_winner),
    .gnt         (arb_gnt),
    .winner      (arb_winner)
  );

  // Transaction sequencer: grant in IDLE, wait for done or timeout in
  // ISSUE, then hold in RELEASE until the SRAM drops done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      last_winner <= 1'(REQ_LOADER);
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata       <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_write   <= 1'b0;
      mem_start   <= 1'b0;
      grant       <= 2'b00;
      busy        <= 1'b0;
    end else begin
      // Completion pulses last exactly one cycle.
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_vec != 2'b00) begin
            if (arb_winner == 1'(REQ_LOADER)) begin
              mem_addr  <= addr1;
              mem_write <= we1;
              mem_wdata <= wdata1;
            end else begin
              mem_addr  <= addr0;
              mem_write <= we0;
              mem_wdata <= wdata0;
            end
            mem_start   <= 1'b1;
            grant       <= arb_gnt;
            last_winner <= arb_winner;
            busy        <= 1'b1;
            cnt         <= 8'd0;
            state       <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (mem_done) begin
            // Writes leave the shared read-data register alone.
            if (!mem_write) begin
              rdata <= mem_rdata;
            end
            mem_start <= 1'b0;
            ack0      <= grant[REQ_CPU];
            ack1      <= grant[REQ_LOADER];
            state     <= ST_RELEASE;
          end else if (cnt == CNT_LAST) begin
            mem_start <= 1'b0;
            ack0      <= grant[REQ_CPU];
            ack1      <= grant[REQ_LOADER];
            err0      <= grant[REQ_CPU];
            err1      <= grant[REQ_LOADER];
            state     <= ST_RELEASE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_RELEASE: begin
          // A late done after a timeout simply extends this wait.
          if (!mem_done) begin
            grant <= 2'b00;
            cnt   <= 8'd0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          mem_start <= 1'b0;
          grant     <= 2'b00;
          cnt       <= 8'd0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kes_mem_arbiter.sv
// Bench for kes_mem_arbiter: one round-robin instance (index 0) and one
// fixed-priority instance (index 1), each with a behavioural SRAM driven
// inline by the transaction task.
module tb_kes_mem_arbiter;

  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req0 [2];
  logic        req1 [2];
  logic        we0 [2];
  logic        we1 [2];
  logic [7:0]  addr0 [2];
  logic [7:0]  addr1 [2];
  logic [31:0] wdata0 [2];
  logic [31:0] wdata1 [2];
  logic        ack0 [2];
  logic        ack1 [2];
  logic        err0 [2];
  logic        err1 [2];
  logic [31:0] rdata [2];
  logic [7:0]  mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic        mem_write [2];
  logic        mem_start [2];
  logic        mem_done [2];
  logic [31:0] mem_rdata [2];
  logic [1:0]  grant [2];
  logic        busy [2];
  logic [1:0]  fsm_state [2];

  kes_mem_arbiter #(.AW(8), .DW(32), .TIMEOUT(TO), .FIXED_PRI(0)) u_rr (
    .clk(clk), .reset(rst),
    .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .ack0(ack0[0]), .ack1(ack1[0]), .err0(err0[0]), .err1(err1[0]),
    .rdata(rdata[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_write(mem_write[0]), .mem_start(mem_start[0]), .mem_done(mem_done[0]),
    .mem_rdata(mem_rdata[0]), .grant(grant[0]), .busy(busy[0]), .fsm_state(fsm_state[0])
  );

  kes_mem_arbiter #(.AW(8), .DW(32), .TIMEOUT(TO), .FIXED_PRI(1)) u_fp (
    .clk(clk), .reset(rst),
    .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .ack0(ack0[1]), .ack1(ack1[1]), .err0(err0[1]), .err1(err1[1]),
    .rdata(rdata[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_write(mem_write[1]), .mem_start(mem_start[1]), .mem_done(mem_done[1]),
    .mem_rdata(mem_rdata[1]), .grant(grant[1]), .busy(busy[1]), .fsm_state(fsm_state[1])
  );

  // ---------------- reference model state ----------------
  int          checks = 0;
  int          errors = 0;
  int          last_win [2];
  logic [31:0] exp_rdata [2];
  logic [31:0] mem_img [2][256];
  logic [41:0] exp_q[$];

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All outputs of instance d at their reset/idle values (rdata per model).
  task automatic chk_quiet(input int d, input string tag);
    chk_b({tag, "_ack0"}, ack0[d], 1'b0);
    chk_b({tag, "_ack1"}, ack1[d], 1'b0);
    chk_b({tag, "_err0"}, err0[d], 1'b0);
    chk_b({tag, "_err1"}, err1[d], 1'b0);
    chk_b({tag, "_start"}, mem_start[d], 1'b0);
    chk_b({tag, "_busy"}, busy[d], 1'b0);
    chk_w({tag, "_grant"}, 64'(grant[d]), 64'(2'b00));
    chk_w({tag, "_state"}, 64'(fsm_state[d]), 64'(2'd0));
    chk_w({tag, "_rdata"}, 64'(rdata[d]), 64'(exp_rdata[d]));
  endtask

  // ---------------- driver: one full transaction ----------------
  // w0/w1: request lines to present; a requester already holding keeps its
  // fields. lat: ISSUE cycle in which the SRAM raises done (0 = never).
  // hold: RELEASE cycles during which done is high. scramble: change the
  // winner's inputs and drop its req right after grant.
  task automatic do_txn(input int d, input bit w0, input bit w1, input int lat,
                        input int hold, input bit scramble);
    int          win;
    bit          hit;
    bit          fin;
    logic        c_we;
    logic [7:0]  c_addr;
    logic [31:0] c_wdata;
    logic [1:0]  g_exp;
    logic        a_w, a_o, e_w, e_o;
    @(negedge clk);
    if (w0 && !req0[d]) begin
      we0[d]    = 1'($urandom_range(0, 1));
      addr0[d]  = 8'($urandom_range(0, 255));
      wdata0[d] = $urandom;
    end
    if (w1 && !req1[d]) begin
      we1[d]    = 1'($urandom_range(0, 1));
      addr1[d]  = 8'($urandom_range(0, 255));
      wdata1[d] = $urandom;
    end
    req0[d] = w0;
    req1[d] = w1;
    // Arbitration rule: lone request wins; tie goes to 0 on the fixed
    // instance, otherwise to whoever did not win last.
    if (w0 && w1) win = (d == 1 || last_win[d] == 1) ? 0 : 1;
    else          win = w1 ? 1 : 0;
    last_win[d] = win;
    c_we    = (win == 1) ? we1[d]    : we0[d];
    c_addr  = (win == 1) ? addr1[d]  : addr0[d];
    c_wdata = (win == 1) ? wdata1[d] : wdata0[d];
    g_exp   = (win == 1) ? 2'b10 : 2'b01;
    exp_q.push_back({1'(win), c_we, c_addr, c_we ? c_wdata : 32'h0});

    @(posedge clk); #1;
    chk_w("grant", 64'(grant[d]), 64'(g_exp));
    chk_b("start_at_grant", mem_start[d], 1'b1);
    chk_b("busy_at_grant", busy[d], 1'b1);
    chk_w("txn_fields", 64'({grant[d][1], mem_write[d], mem_addr[d],
                             mem_write[d] ? mem_wdata[d] : 32'h0}),
          64'(exp_q.pop_front()));

    fin = 1'b0;
    for (int c = 1; c <= TO && !fin; c++) begin
      @(negedge clk);
      if (scramble && c == 1) begin
        if (win == 1) begin
          we1[d] = ~we1[d]; addr1[d] = ~addr1[d]; wdata1[d] = $urandom; req1[d] = 1'b0;
        end else begin
          we0[d] = ~we0[d]; addr0[d] = ~addr0[d]; wdata0[d] = $urandom; req0[d] = 1'b0;
        end
      end
      hit = (lat == c);
      mem_done[d]  = hit;
      mem_rdata[d] = (hit && !c_we) ? mem_img[d][c_addr] : $urandom;
      @(posedge clk); #1;
      if (hit) begin
        if (c_we) mem_img[d][c_addr] = c_wdata;
        else      exp_rdata[d] = mem_img[d][c_addr];
      end
      fin = hit || (c == TO);
      a_w = (win == 1) ? ack1[d] : ack0[d];
      a_o = (win == 1) ? ack0[d] : ack1[d];
      e_w = (win == 1) ? err1[d] : err0[d];
      e_o = (win == 1) ? err0[d] : err1[d];
      chk_b("issue_ack", a_w, fin);
      chk_b("issue_ack_other", a_o, 1'b0);
      chk_b("issue_err", e_w, fin && !hit);
      chk_b("issue_err_other", e_o, 1'b0);
      chk_b("issue_start", mem_start[d], !fin);
      chk_w("issue_grant", 64'(grant[d]), 64'(g_exp));
      chk_w("issue_rdata", 64'(rdata[d]), 64'(exp_rdata[d]));
    end

    for (int r = 1; r <= hold + 1; r++) begin
      @(negedge clk);
      if (r == 1) begin
        if (win == 1) req1[d] = 1'b0;
        else          req0[d] = 1'b0;
      end
      mem_done[d]  = (r <= hold);
      mem_rdata[d] = $urandom;
      @(posedge clk); #1;
      chk_b("rel_ack0", ack0[d], 1'b0);
      chk_b("rel_ack1", ack1[d], 1'b0);
      chk_b("rel_err0", err0[d], 1'b0);
      chk_b("rel_err1", err1[d], 1'b0);
      chk_b("rel_start", mem_start[d], 1'b0);
      chk_b("rel_busy", busy[d], r <= hold);
      chk_w("rel_grant", 64'(grant[d]), 64'((r <= hold) ? g_exp : 2'b00));
      chk_w("rel_state", 64'(fsm_state[d]), 64'((r <= hold) ? 2'd2 : 2'd0));
      chk_w("rel_rdata", 64'(rdata[d]), 64'(exp_rdata[d]));
    end
  endtask

  // Idle cycles with no requests anywhere: nothing may start.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk_quiet(0, "idle_rr");
      chk_quiet(1, "idle_fp");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + randomized sequence ----------------
  initial begin
    int  d;
    bit  w0, w1;
    int  lat, hold;
    bit  scr;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0; we0[i] = 1'b0; we1[i] = 1'b0;
      addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
      mem_done[i] = 1'b0; mem_rdata[i] = '0;
      last_win[i] = 1; exp_rdata[i] = '0;
      for (int a = 0; a < 256; a++) mem_img[i][a] = $urandom;
    end

    // Reset values, both during and right after reset.
    repeat (3) @(posedge clk);
    #1;
    chk_quiet(0, "reset_rr");
    chk_quiet(1, "reset_fp");
    chk_w("reset_mem_addr", 64'(mem_addr[0]), 64'(8'h00));
    chk_b("reset_mem_write", mem_write[0], 1'b0);
    chk_w("reset_mem_wdata", 64'(mem_wdata[0]), 64'(32'h0));
    rst = 1'b0;
    idle_cycles(2);

    // Directed read of 05 returning FFFF_FFFE after 4 cycles.
    mem_img[0][8'h05] = 32'hFFFF_FFFE;
    req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 8'h05; wdata0[0] = 32'h0;
    do_txn(0, 1'b1, 1'b0, 4, 0, 1'b0);
    chk_w("read_rdata", 64'(rdata[0]), 64'(32'hFFFF_FFFE));

    // Directed write of 7 to address 10 from requester 1.
    req1[0] = 1'b1; we1[0] = 1'b1; addr1[0] = 8'h10; wdata1[0] = 32'h0000_0007;
    do_txn(0, 1'b0, 1'b1, 2, 1, 1'b0);
    chk_w("write_rdata_kept", 64'(rdata[0]), 64'(32'hFFFF_FFFE));

    // Round-robin contention: order 01,10,01,10, then drain requester 0.
    for (int i = 0; i < 4; i++) do_txn(0, 1'b1, 1'b1, $urandom_range(1, TO), 0, 1'b0);
    do_txn(0, 1'b1, 1'b0, 3, 0, 1'b0);

    // Fixed priority: requester 1 starves until requester 0 drops.
    for (int i = 0; i < 3; i++) do_txn(1, 1'b1, 1'b1, $urandom_range(1, TO), 0, 1'b0);
    do_txn(1, 1'b0, 1'b1, 2, 0, 1'b0);
    idle_cycles(2);

    // Timeouts: silent SRAM, then SRAM raising done late and holding it.
    do_txn(0, 1'b1, 1'b0, 0, 0, 1'b0);
    do_txn(0, 1'b1, 1'b0, 0, 3, 1'b0);
    // Done arriving on the last ISSUE cycle is a normal completion.
    do_txn(0, 1'b0, 1'b1, TO, 0, 1'b0);
    do_txn(1, 1'b1, 1'b0, 1, 2, 1'b0);
    // Inputs changed and req dropped while the transaction is in flight.
    do_txn(0, 1'b1, 1'b0, 5, 0, 1'b1);
    do_txn(1, 1'b0, 1'b1, 3, 1, 1'b1);
    idle_cycles(1);

    // Randomized traffic; a held request is always served on its own instance.
    for (int i = 0; i < 40; i++) begin
      if (req0[0] || req1[0])      d = 0;
      else if (req0[1] || req1[1]) d = 1;
      else                         d = $urandom_range(0, 1);
      w0 = 1'($urandom_range(0, 1)) | req0[d];
      w1 = 1'($urandom_range(0, 1)) | req1[d];
      if (!w0 && !w1) w0 = 1'b1;
      lat  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
      hold = $urandom_range(0, 2);
      scr  = ($urandom_range(0, 3) == 0);
      do_txn(d, w0, w1, lat, hold, scr);
      if (!req0[0] && !req1[0] && !req0[1] && !req1[1] && $urandom_range(0, 3) == 0)
        idle_cycles(1);
    end
    for (int i = 0; i < 4; i++) begin
      if (req0[0] || req1[0])      do_txn(0, req0[0], req1[0], 2, 0, 1'b0);
      else if (req0[1] || req1[1]) do_txn(1, req0[1], req1[1], 2, 0, 1'b0);
    end

    // Reset in the middle of ISSUE, then clean re-grant of the held req0.
    @(negedge clk);
    req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 8'h33; wdata0[0] = 32'h0;
    mem_done[0] = 1'b0;
    @(posedge clk); #1;
    chk_w("pre_reset_grant", 64'(grant[0]), 64'(2'b01));
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    chk_quiet(0, "midreset_rr");
    chk_quiet(1, "midreset_fp");
    @(posedge clk); #1;
    chk_quiet(0, "inreset_rr");
    rst = 1'b0;
    last_win[0] = 1;
    last_win[1] = 1;
    mem_img[0][8'h33] = 32'hA5A5_0033;
    do_txn(0, 1'b1, 1'b0, 3, 0, 1'b0);
    chk_w("regrant_rdata", 64'(rdata[0]), 64'(32'hA5A5_0033));
    idle_cycles(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kes_mem_arbiter.md
Name: kes_mem_arbiter

Overview:
- Shares the single SRAM256x32 start/write/done port between two requesters: requester 0 is the KES CPU fetch/operand/store path; requester 1 is the program loader/debug port.
- Owns the whole memory handshake: sequences start, waits for done, captures read data, and returns a one-cycle ack to the requester it granted.
- Separate write-data and read-data buses. The top level builds the tristate databus as mem_wdata driven when mem_start and mem_write are both high, otherwise high-Z.

Parameters:
- AW, 8, address width.
- DW, 32, data width.
- TIMEOUT, 64, cycles in ISSUE without mem_done before the transaction is aborted. Legal range is 2..255.
- FIXED_PRI, 0. Value 1 means requester 0 always wins. Value 0 means round-robin.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  transaction request; must be held until the matching ack.
- we0, we1  in  1 each  1 means write, 0 means read.
- addr0, addr1  in  AW each  word address.
- wdata0, wdata1  in  DW each  write data.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- err0, err1  out  1 each  one-cycle timeout pulse, coincident with the ack.
- rdata  out  DW  read data of the last completed read; shared by both requesters.
- mem_addr  out  AW  SRAM address.
- mem_wdata  out  DW  SRAM write data.
- mem_write  out  1  SRAM write enable.
- mem_start  out  1  SRAM start.
- mem_done  in  1  SRAM done; sampled on clk.
- mem_rdata  in  DW  SRAM read data (databus).
- grant  out  2  one-hot owner of the current transaction; 0 when IDLE.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_winner=1 so requester 0 wins the first tie, timeout counter 0.
- All outputs are registered.
- Reset asserted mid-transaction: all outputs clear immediately, including mem_start. No ack or err is produced for the aborted transaction.
- State IDLE, no requests: remain in IDLE.
- State IDLE, any req at edge k:
  - Pick a winner.
  - At edge k load mem_addr, mem_write, mem_wdata from the winner and set mem_start=1 and grant.
  - Go to ISSUE.
- Arbitration when both requests are high in IDLE:
  - FIXED_PRI=1: requester 0 wins.
  - FIXED_PRI=0: the requester that is not last_winner wins.
  - last_winner updates on every grant.
- A lone request always wins, regardless of last_winner.
- State ISSUE: the counter increments each cycle.
  - Edge where mem_done=1: rdata<=mem_rdata (reads only; rdata is unchanged on writes), mem_start<=0, ackN<=1 for the granted requester, go to RELEASE.
  - Counter reaches TIMEOUT-1 with mem_done=0: mem_start<=0, ackN<=1 and errN<=1, rdata unchanged, go to RELEASE.
- State RELEASE:
  - ack and err return to 0 after exactly one cycle.
  - Wait for mem_done=0, then go to IDLE and clear grant and the counter.
  - If mem_done is already 0, leave the next cycle.
  - mem_done rising late in RELEASE after a timeout is ignored; still wait for it to fall.
- No new grant is issued until the SRAM has dropped done, so start never re-asserts while done is high.
- The granted requester's inputs are captured at grant. Later changes, including req dropping, do not affect the transaction in flight; the transaction completes and still acks.
- No back-to-back bypass. Minimum cost per transaction is IDLE + ISSUE + RELEASE = 3 cycles plus SRAM latency.
- A request that is still held after its ack is treated as a new request at the next IDLE.
- Non-granted requester: its ack and err are never asserted.

Decomposition:
- Package/header kes_mem_pkg: AW, DW, state encoding (IDLE=2'd0, ISSUE=2'd1, RELEASE=2'd2), requester index constants.
- Sub-module kes_rr_arb2: combinational winner select from req[1:0], last_winner and FIXED_PRI, producing a one-hot grant. The FSM, counter and datapath registers stay in kes_mem_arbiter.

Test Plan:
- Read: req0=1, we0=0, addr0=8'h05; SRAM model returns 32'hFFFF_FFFE with done 4 cycles after start -> mem_addr=05, mem_write=0, ack0 pulses once, rdata=FFFF_FFFE, grant=01, ack1 never asserts.
- Write: req1=1, we1=1, addr1=8'h10, wdata1=32'h0000_0007 -> mem_write=1, mem_wdata=7 while mem_start=1; ack1 pulses once; rdata unchanged.
- Contention, FIXED_PRI=0, req0 and req1 held high from reset -> grant order 01, 10, 01, 10; each ack pulse is one cycle long.
- Contention, FIXED_PRI=1 -> grants are 01 only; req1 is starved until req0 is dropped, then granted.
- Timeout: TIMEOUT=8, SRAM never raises done -> mem_start falls on the 8th ISSUE cycle, ack0 and err0 pulse together, rdata is unchanged.
- Timeout: when the SRAM later raises and holds done, the arbiter stays in RELEASE, then returns to IDLE when done falls.
- Reset mid-ISSUE -> mem_start, grant and busy are 0 immediately, no ack; after reset deasserts, a pending req0 is re-granted cleanly.
